mips_reg_file: RTL and testbench
================================

Name: mips_reg_file

Overview:
- Architectural register file for the single-cycle MIPS-32 datapath.
- Sources rd1 (ALU operand A) and rd2, which the ALU operand-B select mux chooses between and the sign-extended immediate.
- Accepts the write-back result (ALU result or load data) on the single write port.
- After reset, an internal clear sequencer walks the array to zero before the core may issue instructions. The datapath stalls on o_busy.

Parameters:
- WIDTH, 32, data width of each register.
- DEPTH, 32, number of registers; must be a power of two, minimum 2.
- AW, 5, address width; equals log2(DEPTH).

Ports:
- i_clk  input  1  system clock; all state updates on its rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_ra1  input  AW  read address 1, from instr[25:21] (rs).
- i_ra2  input  AW  read address 2, from instr[20:16] (rt).
- o_rd1  output  WIDTH  read data 1, to ALU operand A.
- o_rd2  output  WIDTH  read data 2, to operand-B mux input 0 and to store data.
- i_we  input  1  write enable (RegWrite).
- i_wa  input  AW  write address (rd or rt, selected upstream).
- i_wd  input  WIDTH  write data from write-back.
- o_busy  output  1  high while the clear sequencer runs; core must stall.

Behaviour:
- Single clock domain i_clk. Reset i_rst_n is asynchronous and active-low: assertion takes effect immediately, deassertion is sampled on the i_clk rising edge.
- Reset clears only control state (FSM, counter). The storage array has no reset, so it can map to distributed RAM.
- Reset values: state=CLEAR, clr_cnt=0, o_busy=1.
- o_rd1 and o_rd2 are 0 while i_rst_n is low, because the outputs are gated by o_busy.
- FSM states:
  - CLEAR: each cycle writes 0 to mem[clr_cnt], then clr_cnt <= clr_cnt+1. When clr_cnt==DEPTH-1, that write completes and the next state is RUN.
  - RUN: normal operation. o_busy=0. The FSM stays in RUN until reset.
- o_busy is a registered output. It is 1 for exactly DEPTH rising edges after reset deassertion and falls on the edge that writes mem[DEPTH-1].
- clr_cnt is AW bits wide. Wrap to 0 is never used, because the FSM leaves CLEAR at DEPTH-1.
- Reset asserted mid-CLEAR or mid-RUN: restart from clr_cnt=0 with o_busy=1, and the full clear reruns.
- Reads are combinational with zero latency: o_rdN = mem[i_raN] in RUN.
- Register 0 is hardwired:
  - i_raN==0 always yields 0.
  - Writes with i_wa==0 are discarded; mem[0] still gets 0 from the clear.
- Write-first bypass. In RUN with i_we=1, i_wa!=0 and i_wa==i_raN, o_rdN = i_wd in the same cycle (combinational).
  - The bypass applies independently per port; both ports may bypass at once.
- Writes: in RUN, mem[i_wa] <= i_wd on the rising edge when i_we=1 and i_wa!=0.
- Busy gating: while o_busy=1, i_we is ignored (no write, no bypass) and o_rd1 = o_rd2 = 0.
- Simultaneous events: a write in the same cycle as the CLEAR to RUN transition is ignored, since o_busy is still 1 during that cycle.
- Identical read addresses: i_ra1==i_ra2 is legal; both ports return the same value.
- Out-of-range addresses cannot occur, because DEPTH equals 2^AW.

Test Plan:
- Reset clear:
  - Stimulus: preload garbage by forcing mem, then pulse i_rst_n low and release it.
  - Required: o_busy=1 for exactly 32 cycles, then 0. After that, every i_ra1 from 0 to 31 reads 0x00000000.
- Write/read:
  - In RUN, write i_wa=5, i_wd=0xDEADBEEF.
  - Next cycle, i_ra1=5 and i_ra2=5 both give 0xDEADBEEF.
  - Write i_wa=31, i_wd=0x1; i_ra2=31 then gives 0x00000001.
- Zero register:
  - Write i_wa=0, i_wd=0xFFFFFFFF.
  - Same cycle and next cycle, i_ra1=0 gives 0; no bypass.
- Bypass:
  - mem[7]=0x11111111. Drive i_we=1, i_wa=7, i_wd=0x22222222, i_ra1=7, i_ra2=8.
  - Same cycle: o_rd1=0x22222222, o_rd2=mem[8]. Next cycle: o_rd1=0x22222222.
- Busy gating:
  - During CLEAR (cycle 10 after reset release), drive i_we=1, i_wa=3, i_wd=0xABCD0000.
  - o_rd1 is 0 throughout. After busy falls, mem[3] reads 0.
  - A write on the final CLEAR cycle is likewise dropped.
- Mid-operation reset:
  - In RUN, write mem[9]=0x55AA55AA, then assert i_rst_n low asynchronously between clock edges.
  - o_busy goes high immediately. A full 32-cycle clear follows, after which mem[9] reads 0.

Source files
------------

// File: rtl/mips_reg_file.sv
// mips_reg_file: 2R1W MIPS register file with post-reset clear sequencer and write-first bypass.
module mips_reg_file #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [AW-1:0]    i_ra1,
  input  logic [AW-1:0]    i_ra2,
  output logic [WIDTH-1:0] o_rd1,
  output logic [WIDTH-1:0] o_rd2,
  input  logic             i_we,
  input  logic [AW-1:0]    i_wa,
  input  logic [WIDTH-1:0] i_wd,
  output logic             o_busy
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t           state;
  logic [AW-1:0]    clr_cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      o_busy  <= 1'b1;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == AW'(DEPTH - 1)) begin
        state  <= RUN;
        o_busy <= 1'b0;
      end
    end
  // Storage has no reset so it can map onto distributed RAM; the sequencer zeroes it instead.
  always_ff @(posedge i_clk)
    if (o_busy) mem[clr_cnt] <= '0;
    else if (i_we && i_wa != '0) mem[i_wa] <= i_wd;
  assign o_rd1 = (o_busy || i_ra1 == '0) ? '0 : (i_we && i_wa == i_ra1) ? i_wd : mem[i_ra1];
  assign o_rd2 = (o_busy || i_ra2 == '0) ? '0 : (i_we && i_wa == i_ra2) ? i_wd : mem[i_ra2];
endmodule

// File: tb/tb_mips_reg_file.sv
// tb_mips_reg_file: randomized + directed scoreboard bench for mips_reg_file.
module tb_mips_reg_file;
  localparam int DEPTH = 32;
  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [4:0]  i_ra1 = '0, i_ra2 = '0, i_wa = '0;
  logic        i_we = 1'b0;
  logic [31:0] i_wd = '0;
  logic [31:0] o_rd1, o_rd2;
  logic        o_busy;
  mips_reg_file dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ra1(i_ra1), .i_ra2(i_ra2),
    .o_rd1(o_rd1), .o_rd2(o_rd2), .i_we(i_we), .i_wa(i_wa), .i_wd(i_wd), .o_busy(o_busy)
  );
  always #5 i_clk = ~i_clk;
  logic [31:0] mdl [DEPTH];
  int edges_since_rst = 0;
  logic [64:0] exp_q [$];
  int vectors = 0;
  int miscompares = 0;
  function automatic logic [31:0] model_read(input logic busy, input logic [4:0] ra);
    if (busy || ra == 0) return 32'h0;
    if (i_we && i_wa == ra) return i_wd;
    return mdl[ra];
  endfunction
  task automatic cyc(input logic rst_n, input logic we, input logic [4:0] wa,
                     input logic [31:0] wd, input logic [4:0] ra1, input logic [4:0] ra2);
    logic busy;
    @(posedge i_clk);
    if (i_rst_n) begin
      if (edges_since_rst == DEPTH) begin
        if (i_we && i_wa != 0) mdl[i_wa] = i_wd;
      end else begin
        edges_since_rst++;
        if (edges_since_rst == DEPTH) foreach (mdl[i]) mdl[i] = 32'h0;
      end
    end
    #1;
    i_rst_n = rst_n; i_we = we; i_wa = wa; i_wd = wd; i_ra1 = ra1; i_ra2 = ra2;
    if (!rst_n) edges_since_rst = 0;
    busy = (edges_since_rst != DEPTH);
    exp_q.push_back({busy, model_read(busy, ra1), model_read(busy, ra2)});
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
    end
  endtask
  always @(negedge i_clk)
    if (exp_q.size() != 0) begin
      logic [64:0] e;
      e = exp_q.pop_front();
      vectors++;
      chk("busy", {31'h0, o_busy}, {31'h0, e[64]});
      chk("rd1", o_rd1, e[63:32]);
      chk("rd2", o_rd2, e[31:0]);
    end
  task automatic idle(input int n, input logic [4:0] ra1, input logic [4:0] ra2);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 5'd0, 32'h0, ra1, ra2);
  endtask
  task automatic clear_with_gating;
    for (int k = 0; k < DEPTH; k++)
      cyc(1'b1, k == 10 || k == DEPTH - 1, 5'd3, 32'hABCD0000, 5'd3, 5'(k));
  endtask
  initial begin
    foreach (mdl[i]) mdl[i] = 32'h0;
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 5'd4, 32'h1234, 5'd4, 5'd0);
    clear_with_gating();
    for (int r = 1; r < DEPTH; r++) cyc(1'b1, 1'b1, 5'(r), $urandom, 5'(r), 5'd0);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd6);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd6);
    clear_with_gating();
    for (int r = 0; r < DEPTH; r++) cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'(r), 5'(DEPTH - 1 - r));
    cyc(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2);
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    cyc(1'b1, 1'b1, 5'd31, 32'h1, 5'd5, 5'd30);
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd31);
    cyc(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    cyc(1'b1, 1'b1, 5'd8, 32'h33333333, 5'd1, 5'd2);
    cyc(1'b1, 1'b1, 5'd7, 32'h11111111, 5'd1, 5'd2);
    cyc(1'b1, 1'b1, 5'd7, 32'h22222222, 5'd7, 5'd8);
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd8);
    cyc(1'b1, 1'b1, 5'd12, 32'hCAFEF00D, 5'd12, 5'd12);
    cyc(1'b1, 1'b1, 5'd9, 32'h55AA55AA, 5'd1, 5'd2);
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    cyc(1'b0, 1'b1, 5'd9, 32'h77777777, 5'd9, 5'd9);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    idle(DEPTH, 5'd9, 5'd7);
    idle(2, 5'd9, 5'd7);
    for (int k = 0; k < 3000; k++) begin
      logic [4:0] wa;
      wa = 5'($urandom);
      cyc($urandom_range(0, 399) != 0, 1'($urandom), wa, $urandom,
          $urandom_range(0, 1) ? wa : 5'($urandom), $urandom_range(0, 2) == 0 ? wa : 5'($urandom));
    end
    @(negedge i_clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
